// File: rtl/latch_mon_pkg.sv
// Shared types and constants for the gated D latch monitor.
// Imported by latch_ref_model and latch_clear_monitor.
package latch_mon_pkg;

    typedef enum logic [1:0] {
        UNKNOWN     = 2'd0,
        CLEARED     = 2'd1,
        TRANSPARENT = 2'd2,
        HOLD        = 2'd3
    } state_t;

    localparam int SETTLE_MAX = 7;
    localparam int SETTLE_W   = 3;

endpackage

// File: rtl/latch_ref_model.sv
// Reference model of an active-low-clear gated D latch.
// Exposes both the registered state/exp_q and their next values.
module latch_ref_model
    import latch_mon_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  logic   clr_n,
    input  logic   d,
    input  logic   g,
    output state_t cur_state,
    output logic   exp_q,
    output state_t nxt_state,
    output logic   nxt_exp
);

    // Next model state: clear beats gate, gate passes d, else hold.
    always_comb begin
        nxt_state = cur_state;
        nxt_exp   = exp_q;
        if (en) begin
            priority case (1'b1)
                !clr_n: begin
                    nxt_state = CLEARED;
                    nxt_exp   = 1'b0;
                end
                g: begin
                    nxt_state = TRANSPARENT;
                    nxt_exp   = d;
                end
                default: begin
                    if (cur_state != UNKNOWN) begin
                        nxt_state = HOLD;
                    end
                end
            endcase
        end
    end

    // Model state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= UNKNOWN;
            exp_q     <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            exp_q     <= nxt_exp;
        end
    end

endmodule

// File: rtl/latch_clear_monitor.sv
// Samples a gated D latch, tracks a reference model and counts mismatches.
// Optional LATCH_MON_FIRST_ERR_EN adds first-mismatch capture outputs.
module latch_clear_monitor
    import latch_mon_pkg::*;
#(
    parameter int CNT_W  = 16,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             check_en,
    input  logic             clr_n,
    input  logic             d,
    input  logic             g,
    input  logic             q,
    output logic             exp_q,
    output logic [1:0]       state,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] sample_count
`ifdef LATCH_MON_FIRST_ERR_EN
    ,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [3:0]       first_err_vec
`endif
);

    localparam int SETTLE_CL = (SETTLE > SETTLE_MAX) ? SETTLE_MAX :
                               ((SETTLE < 0) ? 0 : SETTLE);
    localparam logic [SETTLE_W-1:0] SETTLE_LD = SETTLE_W'(SETTLE_CL);

    logic                v1;
    logic                s_en;
    logic                s_clr_n;
    logic                s_d;
    logic                s_g;
    logic                s_q;
    logic                p_v;
    logic                p_clr_n;
    logic                p_d;
    logic                p_g;
    logic [SETTLE_W-1:0] settle_cnt;
    logic [SETTLE_W-1:0] settle_nxt;
    logic                change;
    logic                do_cmp;
    logic                mismatch;
    state_t              m_state;
    state_t              m_nxt_state;
    logic                m_nxt_exp;

    latch_ref_model u_model (
        .clk       (clk),
        .rst       (rst),
        .en        (v1),
        .clr_n     (s_clr_n),
        .d         (s_d),
        .g         (s_g),
        .cur_state (m_state),
        .exp_q     (exp_q),
        .nxt_state (m_nxt_state),
        .nxt_exp   (m_nxt_exp)
    );

    assign state = m_state;

    // Stage 1: register the observed latch pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1      <= 1'b0;
            s_en    <= 1'b0;
            s_clr_n <= 1'b1;
            s_d     <= 1'b0;
            s_g     <= 1'b0;
            s_q     <= 1'b0;
        end else begin
            v1      <= 1'b1;
            s_en    <= check_en;
            s_clr_n <= clr_n;
            s_d     <= d;
            s_g     <= g;
            s_q     <= q;
        end
    end

    // Settle window and compare qualification for the stage-1 sample.
    always_comb begin
        change = !p_v || (s_clr_n != p_clr_n) ||
                 (s_d != p_d) || (s_g != p_g);
        settle_nxt = '0;
        if (change) begin
            settle_nxt = SETTLE_LD;
        end else if (settle_cnt != '0) begin
            settle_nxt = settle_cnt - 1'b1;
        end
        do_cmp = v1 && s_en && (m_nxt_state != UNKNOWN) &&
                 (settle_nxt == '0);
        mismatch = do_cmp && (s_q != m_nxt_exp);
    end

    // Previous sample and settle counter, advanced per valid sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_v        <= 1'b0;
            p_clr_n    <= 1'b1;
            p_d        <= 1'b0;
            p_g        <= 1'b0;
            settle_cnt <= '0;
        end else if (v1) begin
            p_v        <= 1'b1;
            p_clr_n    <= s_clr_n;
            p_d        <= s_d;
            p_g        <= s_g;
            settle_cnt <= settle_nxt;
        end
    end

    // Stage 2: error pulse, sticky flag and saturating counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_pulse    <= 1'b0;
            err_sticky   <= 1'b0;
            err_count    <= '0;
            sample_count <= '0;
        end else begin
            err_pulse <= mismatch;
            if (do_cmp && !(&sample_count)) begin
                sample_count <= sample_count + CNT_W'(1);
            end
            if (mismatch) begin
                err_sticky <= 1'b1;
                if (!(&err_count)) begin
                    err_count <= err_count + CNT_W'(1);
                end
            end
        end
    end

`ifdef LATCH_MON_FIRST_ERR_EN
    // Freeze index and pin vector of the first mismatch until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_err_idx <= '0;
            first_err_vec <= '0;
        end else if (mismatch && !err_sticky) begin
            first_err_idx <= sample_count;
            first_err_vec <= {s_clr_n, s_d, s_g, s_q};
        end
    end
`endif

endmodule

// File: tb/tb_latch_clear_monitor.sv
// Scoreboard bench for latch_clear_monitor (16-bit and 4-bit counter builds).
// Honours LATCH_MON_FIRST_ERR_EN when defined.
module tb_latch_clear_monitor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic check_en = 1'b1;
    logic clr_n = 1'b1;
    logic d = 1'b0;
    logic g = 1'b0;
    logic q = 1'b0;

    logic        exp_q, exp_q4;
    logic [1:0]  state, state4;
    logic        err_pulse, err_pulse4;
    logic        err_sticky, err_sticky4;
    logic [15:0] err_count, sample_count;
    logic [3:0]  err_count4, sample_count4;
`ifdef LATCH_MON_FIRST_ERR_EN
    logic [15:0] first_err_idx;
    logic [3:0]  first_err_vec;
    logic [3:0]  first_err_idx4;
    logic [3:0]  first_err_vec4;
`endif

    always #5 clk = ~clk;

    latch_clear_monitor #(.CNT_W(16), .SETTLE(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .check_en     (check_en),
        .clr_n        (clr_n),
        .d            (d),
        .g            (g),
        .q            (q),
        .exp_q        (exp_q),
        .state        (state),
        .err_pulse    (err_pulse),
        .err_sticky   (err_sticky),
        .err_count    (err_count),
        .sample_count (sample_count)
`ifdef LATCH_MON_FIRST_ERR_EN
        ,
        .first_err_idx (first_err_idx),
        .first_err_vec (first_err_vec)
`endif
    );

    latch_clear_monitor #(.CNT_W(4), .SETTLE(1)) dut4 (
        .clk          (clk),
        .rst          (rst),
        .check_en     (check_en),
        .clr_n        (clr_n),
        .d            (d),
        .g            (g),
        .q            (q),
        .exp_q        (exp_q4),
        .state        (state4),
        .err_pulse    (err_pulse4),
        .err_sticky   (err_sticky4),
        .err_count    (err_count4),
        .sample_count (sample_count4)
`ifdef LATCH_MON_FIRST_ERR_EN
        ,
        .first_err_idx (first_err_idx4),
        .first_err_vec (first_err_vec4)
`endif
    );

    typedef struct {
        logic       xq;
        logic [1:0] st;
        logic       ep;
        logic       es;
        int         ec;
        int         sc;
        int         ec4;
        int         sc4;
        int         fi;
        logic [3:0] fv;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Independent behavioural model of the monitor.
    int         m_st;
    logic       m_xq;
    int         m_settle;
    bit         m_pv;
    logic       m_pcn, m_pd, m_pg;
    bit         m_es;
    int         m_ec, m_sc, m_ec4, m_sc4, m_fi;
    logic [3:0] m_fv;
    int         tally;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_xq = 1'b0; m_settle = 0; m_pv = 1'b0;
        m_pcn = 1'b1; m_pd = 1'b0; m_pg = 1'b0; m_es = 1'b0;
        m_ec = 0; m_sc = 0; m_ec4 = 0; m_sc4 = 0; m_fi = 0; m_fv = 4'h0;
        sb.delete();
    endtask

    task automatic model_apply(input logic en, input logic cn, input logic dd,
                               input logic gg, input logic qq);
        exp_t e;
        bit   chg, cmp, bad;
        chg = !m_pv || cn != m_pcn || dd != m_pd || gg != m_pg;
        m_pv = 1'b1; m_pcn = cn; m_pd = dd; m_pg = gg;
        if (chg) m_settle = 1;
        else if (m_settle > 0) m_settle--;
        if (!cn) begin
            m_st = 1; m_xq = 1'b0;
        end else if (gg) begin
            m_st = 2; m_xq = dd;
        end else if (m_st != 0) begin
            m_st = 3;
        end
        cmp = en && (m_st != 0) && (m_settle == 0);
        bad = cmp && (qq != m_xq);
        if (bad && !m_es) begin
            m_fi = m_sc;
            m_fv = {cn, dd, gg, qq};
        end
        if (cmp) begin
            if (m_sc < 65535) m_sc++;
            if (m_sc4 < 15) m_sc4++;
        end
        if (bad) begin
            m_es = 1'b1;
            tally++;
            if (m_ec < 65535) m_ec++;
            if (m_ec4 < 15) m_ec4++;
        end
        e.xq = m_xq; e.st = 2'(m_st); e.ep = bad; e.es = m_es;
        e.ec = m_ec; e.sc = m_sc; e.ec4 = m_ec4; e.sc4 = m_sc4;
        e.fi = m_fi; e.fv = m_fv;
        sb.push_back(e);
    endtask

    task automatic step(input logic en, input logic cn, input logic dd,
                        input logic gg, input logic qq);
        exp_t e;
        @(negedge clk);
        rst = 1'b0;
        check_en = en; clr_n = cn; d = dd; g = gg; q = qq;
        model_apply(en, cn, dd, gg, qq);
        @(posedge clk);
        #1;
        if (sb.size() == 2) begin
            e = sb.pop_front();
            check("exp_q", 32'(exp_q), 32'(e.xq));
            check("state", 32'(state), 32'(e.st));
            check("err_pulse", 32'(err_pulse), 32'(e.ep));
            check("err_sticky", 32'(err_sticky), 32'(e.es));
            check("err_count", 32'(err_count), 32'(e.ec));
            check("sample_count", 32'(sample_count), 32'(e.sc));
            check("err_count4", 32'(err_count4), 32'(e.ec4));
            check("sample_count4", 32'(sample_count4), 32'(e.sc4));
`ifdef LATCH_MON_FIRST_ERR_EN
            check("first_err_idx", 32'(first_err_idx), 32'(e.fi));
            check("first_err_vec", 32'(first_err_vec), 32'(e.fv));
`endif
        end
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        model_reset();
        check("rst_exp_q", 32'(exp_q), 32'd0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_err_pulse", 32'(err_pulse), 32'd0);
        check("rst_err_sticky", 32'(err_sticky), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_sample_count", 32'(sample_count), 32'd0);
        check("rst_err_count4", 32'(err_count4), 32'd0);
        check("rst_sample_count4", 32'(sample_count4), 32'd0);
`ifdef LATCH_MON_FIRST_ERR_EN
        check("rst_first_err_idx", 32'(first_err_idx), 32'd0);
        check("rst_first_err_vec", 32'(first_err_vec), 32'd0);
`endif
    endtask

    initial begin
        logic gl;
        logic rd, rg, hd;
        int   t0, s0;
        tally = 0;
        model_reset();

        // 1: reset, then idle with gate low -> no compares
        do_reset(2);
        repeat (10) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("idle_samples", 32'(sample_count), 32'd0);
        check("idle_state", 32'(state), 32'd0);

        // 2: clear with gate high; one wrong q sample
        repeat (4) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        repeat (3) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("clr_err_count", 32'(err_count), 32'd1);
        check("clr_sticky", 32'(err_sticky), 32'd1);

        // 3: golden latch drives q -> no new errors
        t0 = err_count;
        s0 = sample_count;
        gl = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rd = 1'($urandom_range(0, 1));
            rg = 1'($urandom_range(0, 1));
            if (rg) gl = rd;
            step(1'b1, 1'b1, rd, rg, gl);
        end
        step(1'b1, 1'b1, rd, 1'b0, gl);
        step(1'b1, 1'b1, rd, 1'b0, gl);
        check("golden_no_err", 32'(err_count), 32'(t0));
        check("golden_sampled", 32'(sample_count > 16'(s0)), 32'd1);

        // 4: hold with d toggling and q following d
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        t0 = tally;
        s0 = err_count;
        hd = 1'b0;
        for (int i = 0; i < 18; i++) begin
            if (i % 3 == 0) hd = ~hd;
            step(1'b1, 1'b1, hd, 1'b0, hd);
        end
        repeat (4) step(1'b0, 1'b1, hd, 1'b0, hd);
        step(1'b1, 1'b1, hd, 1'b0, hd);
        step(1'b1, 1'b1, hd, 1'b0, hd);
        check("hold_tally", 32'(err_count) - 32'(s0), 32'(tally - t0));

        // 5: constant mismatch saturates the 4-bit counters
        do_reset(1);
        repeat (40) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        check("sat_err4", 32'(err_count4), 32'd15);
        check("sat_smp4", 32'(sample_count4), 32'd15);
        check("sat_err16", 32'(err_count), 32'd38);

        // 6: reset mid-run, then fresh first-error capture
        do_reset(1);
        repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (2) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        repeat (2) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
`ifdef LATCH_MON_FIRST_ERR_EN
        check("first_idx_final", 32'(first_err_idx), 32'd2);
        check("first_vec_final", 32'(first_err_vec), 32'hE);
`endif
        check("post_rst_errs", 32'(err_count), 32'd2);
        do_reset(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
